// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver with a one-word holding register.
// Framed serial bits are collected MSB-first or LSB-first (chosen per frame) into a
// W-bit shift register. Each completed word goes to a valid/ready holding register.
// A word that finds the holding register full and not popping is dropped, and the
// sticky overflow flag is set.
// Optional feature: define SHIFT_DESERIALIZER_PARITY_EN to expect an even-parity bit
// after every word. The parity mismatch is then reported on pe_o.
module shift_deserializer #(
    parameter int unsigned W = 8
) (
    input  logic         c_i,
    input  logic         nrst_i,
    input  logic         si_i,
    input  logic         sv_i,
    input  logic         fr_i,
    input  logic         msb_i,
    input  logic         qr_i,
    input  logic         clr_i,
    output logic [W-1:0] q_o,
    output logic         qv_o,
    output logic         ov_o,
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    output logic         pe_o,
`endif
    output logic         busy_o
);

    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    localparam logic [1:0] StPar   = 2'd2;
`endif

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_q, sh_d;
    logic          dir_q, dir_d;
    logic [W-1:0]  q_q, q_d;
    logic          qv_q, qv_d;
    logic          ov_q, ov_d;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    logic          pe_q, pe_d;
    logic          word_pe;
`endif

    logic          dir_sel;
    logic [W-1:0]  sh_next;
    logic          last_bit;
    logic          word_done;
    logic [W-1:0]  word;
    logic          ovf;

    // A frame-start bit already shifts using the newly presented direction.
    assign dir_sel  = (sv_i && fr_i) ? msb_i : dir_q;
    assign sh_next  = dir_sel ? {sh_q[W-2:0], si_i} : {si_i, sh_q[W-1:1]};
    assign last_bit = (cnt_q == CW'(W - 1));

    // Frame sequencing: collect bits, restart on fr, flag a completed word.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        dir_d     = dir_q;
        word_done = 1'b0;
        word      = sh_next;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        word_pe   = 1'b0;
`endif
        if (sv_i) begin
            if (fr_i) begin
                // Frame start from any state. Any partial word is abandoned.
                state_d = StShift;
                cnt_d   = CW'(1);
                sh_d    = sh_next;
                dir_d   = msb_i;
            end else begin
                case (state_q)
                    StShift: begin
                        sh_d  = sh_next;
                        cnt_d = cnt_q + 1'b1;
                        if (last_bit) begin
                            cnt_d = '0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
                            state_d = StPar;
`else
                            state_d   = StIdle;
                            word_done = 1'b1;
`endif
                        end
                    end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
                    StPar: begin
                        // Parity is even, so XOR of the data and parity bits must be 0.
                        state_d   = StIdle;
                        word      = sh_q;
                        word_pe   = (^sh_q) ^ si_i;
                        word_done = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Holding register: load on completion if empty or popping, else overflow.
    always_comb begin
        q_d  = q_q;
        qv_d = qv_q;
        ovf  = 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        pe_d = pe_q;
`endif
        if (word_done) begin
            if (!qv_q || qr_i) begin
                q_d  = word;
                qv_d = 1'b1;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
                pe_d = word_pe;
`endif
            end else begin
                ovf = 1'b1;
            end
        end else if (qv_q && qr_i) begin
            qv_d = 1'b0;
        end
        // If a new overflow and clr arrive together, the new overflow is kept.
        ov_d = ovf | (ov_q & ~clr_i);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge c_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sh_q    <= '0;
            dir_q   <= 1'b0;
            q_q     <= '0;
            qv_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dir_q   <= dir_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            ov_q    <= ov_d;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            pe_q    <= pe_d;
`endif
        end
    end

    assign q_o    = q_q;
    assign qv_o   = qv_q;
    assign ov_o   = ov_q;
    assign busy_o = (state_q != StIdle);
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    assign pe_o   = pe_q;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer.
// Directed and random serial traffic is checked every cycle against a frame-level
// model. The model keeps the received bits in a queue and assembles each word by
// bit position.
// Define SHIFT_DESERIALIZER_PARITY_EN to also exercise the parity option.
module tb_shift_deserializer;

    localparam int unsigned W = 8;

    logic         c = 1'b0;
    logic         nrst, si, sv, fr, msb, qr, clr;
    logic [W-1:0] q;
    logic         qv, ov, busy;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    logic         pe;
`endif

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state.
    bit           m_busy, m_par, m_dir, m_qv, m_ov, m_pe;
    bit           bits[$];
    logic [W-1:0] m_q, m_word;

    shift_deserializer #(.W(W)) dut (
        .c_i    (c),
        .nrst_i (nrst),
        .si_i   (si),
        .sv_i   (sv),
        .fr_i   (fr),
        .msb_i  (msb),
        .qr_i   (qr),
        .clr_i  (clr),
        .q_o    (q),
        .qv_o   (qv),
        .ov_o   (ov),
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        .pe_o   (pe),
`endif
        .busy_o (busy)
    );

    always #5 c = ~c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_par = 0; m_dir = 0; m_qv = 0; m_ov = 0; m_pe = 0;
        m_q = '0; m_word = '0;
        bits.delete();
    endtask

    // One rising edge of the reference model, using the inputs present at that edge.
    task automatic model_edge();
        bit done, ovf, wpe;
        logic [W-1:0] w;
        done = 0; ovf = 0; wpe = 0; w = '0;
        if (sv) begin
            if (fr) begin
                bits.delete();
                bits.push_back(si);
                m_dir = msb; m_busy = 1; m_par = 0;
            end else if (m_par) begin
                m_par = 0; m_busy = 0; done = 1;
                w = m_word; wpe = (^m_word) ^ si;
            end else if (m_busy) begin
                bits.push_back(si);
            end
            if (m_busy && !m_par && bits.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    if (m_dir) m_word[W-1-i] = bits[i];
                    else       m_word[i]     = bits[i];
                end
                bits.delete();
`ifdef SHIFT_DESERIALIZER_PARITY_EN
                m_par = 1;
`else
                m_busy = 0; done = 1; w = m_word;
`endif
            end
        end
        if (done) begin
            if (!m_qv || qr) begin
                m_q = w; m_qv = 1; m_pe = wpe;
            end else begin
                ovf = 1;
            end
        end else if (m_qv && qr) begin
            m_qv = 0;
        end
        m_ov = ovf | (m_ov & !clr);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".q"}, 32'(q), 32'(m_q));
        chk({tag, ".qv"}, 32'(qv), 32'(m_qv));
        chk({tag, ".ov"}, 32'(ov), 32'(m_ov));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        if (m_qv) chk({tag, ".pe"}, 32'(pe), 32'(m_pe));
`endif
    endtask

    // Inputs change on the falling edge. Outputs are sampled on the next falling edge.
    task automatic step(input bit s_si, input bit s_sv, input bit s_fr, input bit s_msb);
        si = s_si; sv = s_sv; fr = s_fr; msb = s_msb;
        @(posedge c);
        model_edge();
        @(negedge c);
        compare_all("step");
    endtask

    // Sends a frame with data[W-1] first, optionally with random idle gaps.
    // In parity builds an even-parity bit (or its inverse) is appended.
    task automatic send(input logic [W-1:0] data, input bit dir, input bit gaps,
                        input bit bad_par = 0);
        for (int i = W - 1; i >= 0; i--) begin
            if (gaps) begin
                int n = $urandom_range(0, 2);
                for (int g = 0; g < n; g++) step($urandom_range(0, 1), 0, $urandom_range(0, 1), 0);
            end
            step(data[i], 1, (i == W - 1), dir);
        end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        step((^data) ^ bad_par, 1, 0, 0);
`endif
    endtask

    initial begin
        nrst = 0; si = 0; sv = 0; fr = 0; msb = 0; qr = 0; clr = 0;
        model_reset();
        #12;
        chk("rst.q", 32'(q), 0);
        chk("rst.qv", 32'(qv), 0);
        chk("rst.ov", 32'(ov), 0);
        chk("rst.busy", 32'(busy), 0);
        @(negedge c);
        nrst = 1;

        // MSB-first A5
        send(8'hA5, 1, 0);
        chk("msb.a5", 32'(q), 32'hA5);
        chk("msb.a5.qv", 32'(qv), 1);
        qr = 1; step(0, 0, 0, 0); qr = 0;
        chk("pop.qv", 32'(qv), 0);

        // One leading 1: LSB-first gives 01, MSB-first gives 80
        send(8'h80, 0, 0);
        chk("lsb.01", 32'(q), 32'h01);
        qr = 1; step(0, 0, 0, 0); qr = 0;
        send(8'h80, 1, 0);
        chk("msb.80", 32'(q), 32'h80);
        qr = 1; step(0, 0, 0, 0); qr = 0;

        // Gapped strobes
        send(8'hA5, 1, 1);
        chk("gap.a5", 32'(q), 32'hA5);
        qr = 1; step(0, 0, 0, 0); qr = 0;

        // Restart after 5 bits
        for (int i = 0; i < 5; i++) step($urandom_range(0, 1), 1, (i == 0), 1);
        chk("restart.busy", 32'(busy), 1);
        send(8'h3C, 1, 0);
        chk("restart.3c", 32'(q), 32'h3C);
        qr = 1; step(0, 0, 0, 0); qr = 0;

        // Backpressure and overflow
        send(8'h11, 1, 0);
        send(8'h22, 1, 0);
        chk("ovf.q", 32'(q), 32'h11);
        chk("ovf.ov", 32'(ov), 1);
        chk("ovf.busy", 32'(busy), 0);
        // Pop and load at the same edge: the new word replaces the old one, ov stays set
        for (int i = W - 1; i >= 0; i--) begin
`ifndef SHIFT_DESERIALIZER_PARITY_EN
            qr = (i == 0);
`endif
            step(i == 0 || i == 1, 1, (i == W - 1), 1);
        end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        qr = 1; step(0, 1, 0, 0);
`endif
        qr = 0;
        chk("popload.q", 32'(q), 32'h03);
        chk("popload.qv", 32'(qv), 1);
        chk("popload.ov", 32'(ov), 1);
        clr = 1; step(0, 0, 0, 0); clr = 0;
        chk("clr.ov", 32'(ov), 0);

        // Async reset mid-frame while a word is held
        for (int i = 0; i < 3; i++) step(1, 1, (i == 0), 1);
        @(negedge c);
        #2 nrst = 0;
        #1;
        model_reset();
        chk("arst.q", 32'(q), 0);
        chk("arst.qv", 32'(qv), 0);
        chk("arst.ov", 32'(ov), 0);
        chk("arst.busy", 32'(busy), 0);
        @(negedge c);
        nrst = 1;
        send(8'h5A, 0, 0);
        chk("fresh.5a", 32'(q), 32'h5A);
        qr = 1; step(0, 0, 0, 0); qr = 0;

`ifdef SHIFT_DESERIALIZER_PARITY_EN
        for (int i = W - 1; i >= 0; i--) step(i < 2, 1, (i == W - 1), 1);
        chk("par.wait.qv", 32'(qv), 0);
        chk("par.wait.busy", 32'(busy), 1);
        step(0, 1, 0, 0);
        chk("par.ok.qv", 32'(qv), 1);
        chk("par.ok.pe", 32'(pe), 0);
        qr = 1; step(0, 0, 0, 0); qr = 0;
        send(8'h03, 1, 0, 1);
        chk("par.bad.pe", 32'(pe), 1);
        qr = 1; step(0, 0, 0, 0); qr = 0;
`endif

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            qr  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 1), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 1));
        end
        qr = 0; clr = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Serial-to-parallel receiver: the receiving end of the team's parallel-load/serial-shift register.
- Collects framed serial bits into a W-bit word, MSB-first or LSB-first, selected per frame.
- Double-buffered: a shift register plus a one-word holding register.
- Presents words on a valid/ready output; flags overruns with a sticky overflow bit.

Parameters:
- W, 8, data word width in bits (W >= 2).

Ports:
- c  input  1  clock; all state updates on rising edge.
- nrst  input  1  asynchronous active-low reset.
- si  input  1  serial data bit.
- sv  input  1  serial bit strobe; si sampled only when sv=1.
- fr  input  1  frame start; meaningful only with sv=1; marks si as first bit of a word.
- msb  input  1  direction, sampled with the frame-start bit: 1 = MSB-first (shift left), 0 = LSB-first (shift right).
- qr  input  1  consumer ready.
- clr  input  1  clears ov.
- q  output  W  received word (holding register).
- qv  output  1  holding register full.
- ov  output  1  sticky overflow.
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Reset (nrst=0, async): state=IDLE, bit counter=0, shift reg=0, q=0, qv=0, ov=0, busy=0, latched direction=0.
- States: IDLE, SHIFT (PAR added under the optional feature).
- Cycles with sv=0 change nothing in the shift path. fr with sv=0 is ignored.
- IDLE, sv=1 and fr=0: bit discarded, stay IDLE.
- IDLE, sv=1 and fr=1: latch msb as dir; shift si in; cnt=1; go SHIFT.
- SHIFT, sv=1 and fr=0: shift si in; cnt+1.
- SHIFT, sv=1 and fr=1: abort the current partial word, restart the frame. Same as the IDLE frame-start action (cnt=1, dir re-latched). No flag raised.
- Shift rule, dir=1: sh <= {sh[W-2:0], si}. First bit ends at q[W-1].
- Shift rule, dir=0: sh <= {si, sh[W-1:1]}. First bit ends at q[0].
- Word complete: the edge capturing the W-th bit forms the word (sh with si included) and returns to IDLE.
- Word delivery: the completed word loads the holding register if qv=0 or the holding register pops in the same cycle. Then q=word and qv=1 in the cycle after the edge that captured the last bit (latency 1 from last sv).
- Pop: qv=1 and qr=1 at an edge. qv clears unless a word loads at the same edge; simultaneous pop+load keeps qv=1 with the new q.
- Overflow: word complete while qv=1 and qr=0. The new word is dropped, q unchanged, ov set.
- ov clears only on clr=1. If set and clr coincide, set wins.
- q holds its value when qv=0 (no clearing on pop).
- Counter width: clog2(W+1). cnt is never observable outside SHIFT.
- busy = (state != IDLE).
- Reset mid-frame discards the partial word and any held word.

Optional Feature:
- Macro: SHIFT_DESERIALIZER_PARITY_EN.
- Enabled:
  - After the W-th data bit, go to PAR instead of delivering. The next sv=1 bit is an even-parity bit over the W data bits.
  - Delivery/overflow rules then apply at the parity edge; latency is 1 cycle from the parity strobe.
  - Extra output pe (1 bit, reset 0): loaded with the parity mismatch alongside q, valid when qv=1.
  - fr=1 with sv=1 in PAR restarts the frame; the word is dropped.
- Disabled: no PAR state, no pe port; behaviour exactly as above.

Test Plan:
- MSB-first: fr+msb=1 on first bit, bits 1,0,1,0,0,1,0,1 -> qv=1 one cycle after last strobe, q=8'hA5, ov=0.
- LSB-first: msb=0, same bit sequence -> q=8'hA5 reversed = 8'hA5? Use bits 1,0,0,0,0,0,0,0 instead -> q=8'h01; with msb=1 the same bits give q=8'h80.
- Gapped strobes and restart:
  - Random sv=0 gaps between bits -> result identical to the ungapped case.
  - fr=1 after 5 bits -> partial word dropped; the next 8 bits form q.
- Backpressure:
  - qr=0 and two full words (8'h11 then 8'h22) -> q=8'h11, ov=1, busy=0.
  - clr=1 -> ov=0.
  - Word completing at the same edge as a qr=1 pop -> qv stays 1, q takes the new word, ov unchanged.
- Async reset mid-frame: nrst=0 after 3 bits with qv=1 -> q=0, qv=0, ov=0, busy=0 immediately. A following fresh frame delivers correctly.
- Parity (macro defined): word 8'h03 with parity bit 0 -> pe=0. Same word with parity bit 1 -> pe=1. qv asserts one cycle after the parity strobe.
